wallace_row_resolver: RTL and testbench

WALLACE_ROW_RESOLVER -- requirements
Module: wallace_row_resolver

---
 rtl/wallace_row_resolver_pkg.sv | 18 +
 rtl/wallace_row_resolver_rca.sv | 27 ++
 rtl/wallace_row_resolver.sv | 124 ++++++++++++
 tb/tb_wallace_row_resolver.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wallace_row_resolver_pkg.sv
// Shared multiplier package: the default row and split widths, plus the
// stage-1 payload carried between the two halves of the final adder.
package wallace_row_resolver_pkg;

  localparam int MUL_W     = 10;
  localparam int MUL_SPLIT = 5;
  localparam int MUL_HW    = MUL_W - MUL_SPLIT;

  // Registered after the low-slice add: the low sum, its carry, and the
  // untouched high slices waiting for stage 2.
  typedef struct packed {
    logic [MUL_SPLIT-1:0] lo;
    logic                 c;
    logic [MUL_HW-1:0]    r1_hi;
    logic [MUL_HW-1:0]    r2_hi;
  } s1_payload_t;

endpackage

// File: rtl/wallace_row_resolver_rca.sv
// Parameterised ripple-carry adder slice: sum = a + b + cin, cout = carry out.
module rca_slice #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  // Bit-serial carry chain, one full adder per bit.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < N; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[N];

endmodule

// File: rtl/wallace_row_resolver.sv
// Final carry-propagate adder for the reduction tree: adds the sum and carry
// rows in two pipelined slices (low slice, then high slice with the low carry).
// The stage-1 payload type follows the package widths, so W/SPLIT overrides
// must be made in the package rather than on the instance.
module wallace_row_resolver
  import wallace_row_resolver_pkg::*;
#(
  parameter int W     = MUL_W,
  parameter int SPLIT = MUL_SPLIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] r1,
  input  logic [W-1:0] r2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] product,
  output logic         ovf,
  output logic         ovf_sticky
);

  localparam int HW = W - SPLIT;

  // Handshake: a side transfers on the rising edge where valid && ready are
  // both high. in_ready depends only on stage occupancy, out_ready and rst,
  // never on in_valid; out_valid is the stage-2 valid flop. A stage loads
  // when it is empty or its contents move downstream in the same cycle.

  logic          s1_valid_q, s1_valid_d;
  logic          s2_valid_q, s2_valid_d;
  s1_payload_t   s1_q, s1_d;
  logic [W-1:0]  product_q, product_d;
  logic          ovf_q, ovf_d;
  logic          ovf_sticky_q, ovf_sticky_d;

  logic [SPLIT-1:0] lo_sum;
  logic             lo_cout;
  logic [HW-1:0]    hi_sum;
  logic             hi_cout;

  logic in_fire;
  logic out_fire;
  logic s2_load;

  rca_slice #(.N(SPLIT)) u_lo_slice (
    .a    (r1[SPLIT-1:0]),
    .b    (r2[SPLIT-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  rca_slice #(.N(HW)) u_hi_slice (
    .a    (s1_q.r1_hi),
    .b    (s1_q.r2_hi),
    .cin  (s1_q.c),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  // Handshake decode: stage 2 drains on out_ready, stage 1 advances into an
  // empty or draining stage 2, input is refused only when both are stuck.
  always_comb begin
    in_ready = !rst && (!s1_valid_q || !s2_valid_q || out_ready);
    in_fire  = in_valid && in_ready;
    out_fire = s2_valid_q && out_ready;
    s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  end

  // Next-state for both stages; payloads only change when their stage loads.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_d         = s1_q;
    s2_valid_d   = s2_valid_q;
    product_d    = product_q;
    ovf_d        = ovf_q;
    ovf_sticky_d = ovf_sticky_q | (out_fire & ovf_q);

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_d.lo    = lo_sum;
      s1_d.c     = lo_cout;
      s1_d.r1_hi = r1[W-1:SPLIT];
      s1_d.r2_hi = r2[W-1:SPLIT];
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      product_d  = {hi_sum, s1_q.lo};
      ovf_d      = hi_cout;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset discarding any in-flight pairs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      s2_valid_q   <= 1'b0;
      product_q    <= '0;
      ovf_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_q         <= s1_d;
      s2_valid_q   <= s2_valid_d;
      product_q    <= product_d;
      ovf_q        <= ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign product    = product_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_wallace_row_resolver.sv
// Bench for wallace_row_resolver: an occupancy/queue model of the two-slot
// pipeline checked every cycle, plus directed literal cases.
module tb_wallace_row_resolver;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] r1 = '0;
  logic [W-1:0] r2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] product;
  logic         ovf;
  logic         ovf_sticky;

  int total = 0;
  int bad   = 0;

  // Expected {ovf, product} of every accepted pair, in acceptance order.
  logic [W:0]   exp_q[$];
  // Expected a*b for pairs fed from the bench's reduction tree.
  logic [W-1:0] mul_q[$];
  logic         model_sticky = 1'b0;

  always #5 clk = ~clk;

  wallace_row_resolver dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .r1         (r1),
    .r2         (r2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .ovf        (ovf),
    .ovf_sticky (ovf_sticky)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: sampled on the falling edge, transfers happen on the
  // following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_during_reset", 32'(in_ready), 32'd0);
      exp_q.delete();
      mul_q.delete();
      model_sticky = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2 || out_ready));
      chk("ovf_sticky", 32'(ovf_sticky), 32'(model_sticky));
      if (exp_q.size() == 0) chk("no_stale_out_valid", 32'(out_valid), 32'd0);
      else if (exp_q.size() == 2) chk("full_out_valid", 32'(out_valid), 32'd1);
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        chk("product", 32'(product), 32'(exp_q[0][W-1:0]));
        chk("ovf", 32'(ovf), 32'(exp_q[0][W]));
        if (out_ready) begin
          if (exp_q[0][W]) model_sticky = 1'b1;
          void'(exp_q.pop_front());
          if (mul_q.size() > 0) begin
            chk("mul_product", 32'(product), 32'(mul_q[0]));
            void'(mul_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back({1'b0, r1} + {1'b0, r2});
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle reset pulse with a pair offered that must be ignored.
  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    r1       = W'($urandom);
    r2       = W'($urandom);
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  // Offer a pair and hold it until accepted; in_valid is left high.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    logic acc;
    int   n;
    n        = 0;
    r1       = a;
    r2       = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      step();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Carry-save reduction of the 5x5 partial products down to two rows.
  function automatic void reduce(input int a, input int b,
                                 output logic [W-1:0] s, output logic [W-1:0] c);
    int x, y, pp, t;
    x = (b & 1) ? a : 0;
    y = (b & 2) ? (a << 1) : 0;
    for (int i = 2; i < 5; i++) begin
      pp = ((b >> i) & 1) ? (a << i) : 0;
      t  = x ^ y ^ pp;
      y  = ((x & y) | (x & pp) | (y & pp)) << 1;
      x  = t;
    end
    s = x[W-1:0];
    c = y[W-1:0];
  endfunction

  initial begin
    logic [W-1:0] ra, rb;
    int sent, acc_low, stall_seen, acc, cyc;

    // Reset and the carry-across-split case.
    step();
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    r1        = 10'h1F0;
    r2        = 10'h010;
    in_valid  = 1'b1;
    @(negedge clk);
    chk("reset_product", 32'(product), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sticky", 32'(ovf_sticky), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_cycle1_out_valid", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    chk("latency_cycle2_out_valid", 32'(out_valid), 32'd1);
    chk("split_carry_product", 32'(product), 32'h200);
    chk("split_carry_ovf", 32'(ovf), 32'd0);
    step();

    // Overflow case and sticky flag.
    r1       = 10'h3FF;
    r2       = 10'h001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("ovf_case_out_valid", 32'(out_valid), 32'd1);
    chk("ovf_case_product", 32'(product), 32'h000);
    chk("ovf_case_ovf", 32'(ovf), 32'd1);
    chk("ovf_case_sticky_before", 32'(ovf_sticky), 32'd0);
    step();
    @(negedge clk);
    chk("ovf_case_sticky_after", 32'(ovf_sticky), 32'd1);
    step();
    do_reset();
    @(negedge clk);
    chk("sticky_cleared_by_reset", 32'(ovf_sticky), 32'd0);
    step();

    // Exhaustive 5x5 products through the bench reduction tree.
    out_ready = 1'b1;
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        reduce(a, b, ra, rb);
        mul_q.push_back(W'(a * b));
        send(ra, rb);
      end
    end
    drain();
    @(negedge clk);
    chk("exhaustive_sticky", 32'(ovf_sticky), 32'd0);
    step();

    // Eight pairs streamed with out_ready low on cycles 3..6.
    do_reset();
    sent       = 0;
    acc_low    = 0;
    stall_seen = 0;
    r1         = W'($urandom);
    r2         = W'($urandom);
    for (int c = 0; c < 60 && sent < 8; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        sent++;
        if (!out_ready) acc_low++;
      end else if (!out_ready) begin
        stall_seen = 1;
      end
      step();
      if (in_ready || sent > 0) begin
        r1 = W'($urandom);
        r2 = W'($urandom);
      end
    end
    in_valid = 1'b0;
    chk("stream_sent", 32'(sent), 32'd8);
    chk("stream_stall_seen", 32'(stall_seen), 32'd1);
    chk("stream_accepted_while_stalled_le2", 32'(acc_low <= 2), 32'd1);
    drain();

    // Reset with both stages full: nothing from before may emerge.
    do_reset();
    out_ready = 1'b0;
    send(W'($urandom), W'($urandom));
    send(W'($urandom), W'($urandom));
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready_low", 32'(in_ready), 32'd0);
    chk("full_out_valid_high", 32'(out_valid), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_out_valid", 32'(out_valid), 32'd0);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    step();
    out_ready = 1'b1;
    repeat (4) step();

    // Random valid/ready traffic.
    do_reset();
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 70000) begin
      if (!in_valid) begin
        in_valid = 1'($urandom_range(0, 1));
        r1       = W'($urandom);
        r2       = W'($urandom);
      end
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      step();
      if (in_valid && acc > 0 && exp_q.size() > 0) begin
        // Accepted pairs are replaced by a fresh offer decision next cycle.
      end
      cyc++;
      if (in_valid && acc_marker_accepted(acc)) in_valid = 1'b0;
    end
    chk("random_pairs_accepted", 32'(acc), 32'd10000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Tracks the last accepted count so the random driver can tell whether
  // the pair it was holding has just been taken.
  int last_acc = 0;
  function automatic logic acc_marker_accepted(input int acc_now);
    logic taken;
    taken    = (acc_now != last_acc);
    last_acc = acc_now;
    return taken;
  endfunction

endmodule
